riscv_mc_ctrl: RTL and testbench

//  Control FSM for the multi-cycle RV32I core. Sequences the shared datapath: PC/IR/OldPC regs, regfile, one ALU,

---
 rtl/riscv_mc_ctrl_pkg.sv | 85 ++++++++
 rtl/riscv_alu_dec.sv | 32 +++
 rtl/riscv_mc_ctrl.sv | 179 +++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_ctrl_pkg.sv
// rtl/riscv_mc_ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control FSM
package riscv_mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALR_WB  = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14
    } state_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] SRC_IMM_I = 3'd0;
    localparam logic [2:0] SRC_IMM_S = 3'd1;
    localparam logic [2:0] SRC_IMM_B = 3'd2;
    localparam logic [2:0] SRC_IMM_U = 3'd3;
    localparam logic [2:0] SRC_IMM_J = 3'd4;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RD1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RD2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // Which flavour of ALU decode the current state asks for.
    typedef enum logic [1:0] {
        ALU_CLS_ADD = 2'd0,
        ALU_CLS_SUB = 2'd1,
        ALU_CLS_R   = 2'd2,
        ALU_CLS_I   = 2'd3
    } alu_cls_e;

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_dec.sv
// rtl/riscv_alu_dec.sv - maps state class and funct fields to the ALU operation code
module riscv_alu_dec
    import riscv_mc_ctrl_pkg::*;
(
    input  alu_cls_e   cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (cls)
            ALU_CLS_ADD: alu_ctrl = ALU_ADD;
            ALU_CLS_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    // Immediate forms have no SUBI, so funct7_5 only matters for R-type here.
                    3'b000:  alu_ctrl = (cls == ALU_CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - control FSM sequencing the shared multi-cycle RV32I datapath
module riscv_mc_ctrl
    import riscv_mc_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [2:0] o_imm_src,
    output logic [3:0] o_alu_ctrl,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    state_e   state_q;
    state_e   state_n;
    state_e   dec_state;
    alu_cls_e alu_cls;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_FETCH;
        else       state_q <= state_n;
    end

    // Outputs decode as FETCH while reset is held, so a pending memory access drops immediately.
    assign dec_state = i_rst ? S_FETCH : state_q;
    assign o_state   = state_q;

    always_comb begin
        state_n      = S_FETCH;
        o_pc_write   = 1'b0;
        o_ir_write   = 1'b0;
        o_adr_src    = 1'b0;
        o_mem_write  = 1'b0;
        o_reg_write  = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RD2;
        o_imm_src    = SRC_IMM_I;
        o_illegal    = 1'b0;
        alu_cls      = ALU_CLS_ADD;
        case (dec_state)
            S_FETCH: begin
                o_alu_src_a  = SRCA_PC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURESULT;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
                state_n      = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = (i_opcode == OPC_BRANCH) ? SRC_IMM_B :
                              (i_opcode == OPC_JAL)    ? SRC_IMM_J : SRC_IMM_I;
                case (i_opcode)
                    OPC_LOAD, OPC_STORE:      state_n = S_MEMADR;
                    OPC_OP:                   state_n = S_EXEC_R;
                    OPC_OP_IMM:               state_n = S_EXEC_I;
                    OPC_JAL:                  state_n = S_JAL;
                    OPC_JALR:                 state_n = S_JALR;
                    OPC_BRANCH:               state_n = S_BRANCH;
                    OPC_LUI:                  state_n = S_LUI;
                    OPC_AUIPC:                state_n = S_AUIPC;
                    OPC_MISC_MEM, OPC_SYSTEM: state_n = S_FETCH;
                    default: begin
                        state_n   = S_FETCH;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = (i_opcode == OPC_STORE) ? SRC_IMM_S : SRC_IMM_I;
                state_n     = (i_opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                o_adr_src    = 1'b1;
                o_result_src = RES_ALUOUT;
                state_n      = i_mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                o_result_src = RES_DATA;
                o_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src    = 1'b1;
                o_result_src = RES_ALUOUT;
                o_mem_write  = 1'b1;
                state_n      = i_mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_RD2;
                alu_cls     = ALU_CLS_R;
                state_n     = S_ALUWB;
            end
            S_EXEC_I: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
                alu_cls     = ALU_CLS_I;
                state_n     = S_ALUWB;
            end
            S_ALUWB: begin
                o_result_src = RES_ALUOUT;
                o_reg_write  = 1'b1;
            end
            S_JAL: begin
                o_result_src = RES_ALUOUT;
                o_pc_write   = 1'b1;
                o_alu_src_a  = SRCA_OLDPC;
                o_alu_src_b  = SRCB_FOUR;
                state_n      = S_ALUWB;
            end
            S_JALR: begin
                o_alu_src_a  = SRCA_RD1;
                o_alu_src_b  = SRCB_IMM;
                o_result_src = RES_ALURESULT;
                o_pc_write   = 1'b1;
                state_n      = S_JALR_WB;
            end
            S_JALR_WB: begin
                o_alu_src_a  = SRCA_OLDPC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURESULT;
                o_reg_write  = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a  = SRCA_RD1;
                o_alu_src_b  = SRCB_RD2;
                o_result_src = RES_ALUOUT;
                alu_cls      = ALU_CLS_SUB;
                o_pc_write   = branch_taken(i_funct3, i_zero, i_lt, i_ltu);
            end
            S_LUI: begin
                o_alu_src_a = SRCA_ZERO;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = SRC_IMM_U;
                state_n     = S_ALUWB;
            end
            S_AUIPC: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = SRC_IMM_U;
                state_n     = S_ALUWB;
            end
            default: state_n = S_FETCH;
        endcase
        if (i_rst) begin
            o_pc_write  = 1'b0;
            o_ir_write  = 1'b0;
            o_mem_write = 1'b0;
            o_reg_write = 1'b0;
            o_illegal   = 1'b0;
        end
    end

    riscv_alu_dec u_alu_dec (
        .cls      (alu_cls),
        .funct3   (i_funct3),
        .funct7_5 (i_funct7_5),
        .alu_ctrl (o_alu_ctrl)
    );

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb/tb_riscv_mc_ctrl.sv - directed and randomized self-checking bench for riscv_mc_ctrl
module tb_riscv_mc_ctrl;
    import riscv_mc_ctrl_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [6:0] i_opcode;
    logic [2:0] i_funct3;
    logic       i_funct7_5;
    logic       i_zero;
    logic       i_lt;
    logic       i_ltu;
    logic       i_mem_ready;
    logic       o_pc_write;
    logic       o_ir_write;
    logic       o_adr_src;
    logic       o_mem_write;
    logic       o_reg_write;
    logic [1:0] o_result_src;
    logic [1:0] o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [2:0] o_imm_src;
    logic [3:0] o_alu_ctrl;
    logic       o_illegal;
    logic [3:0] o_state;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 i_clk = ~i_clk;

    riscv_mc_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_opcode     (i_opcode),
        .i_funct3     (i_funct3),
        .i_funct7_5   (i_funct7_5),
        .i_zero       (i_zero),
        .i_lt         (i_lt),
        .i_ltu        (i_ltu),
        .i_mem_ready  (i_mem_ready),
        .o_pc_write   (o_pc_write),
        .o_ir_write   (o_ir_write),
        .o_adr_src    (o_adr_src),
        .o_mem_write  (o_mem_write),
        .o_reg_write  (o_reg_write),
        .o_result_src (o_result_src),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_imm_src    (o_imm_src),
        .o_alu_ctrl   (o_alu_ctrl),
        .o_illegal    (o_illegal),
        .o_state      (o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at the following negedge.
    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st);
        i_mem_ready = rdy;
        #4;
        chk(tag, o_state, st);
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        i_opcode   = opc;
        i_funct3   = f3;
        i_funct7_5 = f7;
    endtask

    // Reference model tables: ALU codes by funct3 for the plain (non-alternate) operations.
    logic [3:0] base_op  [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    logic [6:0] opc_tab [14] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                                 7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111, 7'b0001111,
                                 7'b1110011, 7'b0000000, 7'b1111111, 7'b0101011};

    int         kf, km, d, total, pcw2, rw, mw_lo, mw_hi, ill, mdone, alu_cyc;
    logic [3:0] alu_exp;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7, z, lt, ltu, taken, rdy;

    initial begin
        i_rst = 1'b1;
        set_instr(7'b0110011, 3'd0, 1'b0);
        i_zero = 1'b0; i_lt = 1'b0; i_ltu = 1'b0; i_mem_ready = 1'b1;
        adv();
        cyc("rst_state", 1'b1, S_FETCH);
        chk("rst_pcw", o_pc_write, 0);
        chk("rst_irw", o_ir_write, 0);
        chk("rst_b_sel", o_alu_src_b, 2);
        adv();
        i_rst = 1'b0;

        // ADD: FETCH, DECODE, EXEC_R, ALUWB
        cyc("add_fetch", 1'b1, S_FETCH);
        chk("add_fetch_irw", o_ir_write, 1);
        chk("add_fetch_res", o_result_src, 2);
        chk("add_fetch_rw", o_reg_write, 0);
        adv();
        cyc("add_decode", 1'b1, S_DECODE);
        chk("add_decode_a", o_alu_src_a, 1);
        chk("add_decode_rw", o_reg_write, 0);
        adv();
        cyc("add_exec", 1'b1, S_EXEC_R);
        chk("add_alu", o_alu_ctrl, 0);
        chk("add_exec_rw", o_reg_write, 0);
        adv();
        cyc("add_wb", 1'b1, S_ALUWB);
        chk("add_wb_rw", o_reg_write, 1);
        adv();
        cyc("add_done", 1'b1, S_FETCH);

        // SUB, ADDI with funct7_5, SRAI
        set_instr(7'b0110011, 3'd0, 1'b1);
        adv(); adv();
        cyc("sub_exec", 1'b1, S_EXEC_R);
        chk("sub_alu", o_alu_ctrl, 1);
        adv(); adv();
        set_instr(7'b0010011, 3'd0, 1'b1);
        adv(); adv();
        cyc("addi_exec", 1'b1, S_EXEC_I);
        chk("addi_alu", o_alu_ctrl, 0);
        adv(); adv();
        set_instr(7'b0010011, 3'b101, 1'b1);
        adv(); adv();
        cyc("srai_exec", 1'b1, S_EXEC_I);
        chk("srai_alu", o_alu_ctrl, 7);
        adv(); adv();

        // BNE with zero=0 is taken; BGEU with ltu=1 is not
        set_instr(7'b1100011, 3'b001, 1'b0);
        adv();
        cyc("bne_decode", 1'b1, S_DECODE);
        chk("bne_imm", o_imm_src, 2);
        adv();
        cyc("bne_branch", 1'b1, S_BRANCH);
        chk("bne_pcw", o_pc_write, 1);
        chk("bne_alu", o_alu_ctrl, 1);
        adv();
        cyc("bne_done", 1'b1, S_FETCH);
        set_instr(7'b1100011, 3'b111, 1'b0);
        i_ltu = 1'b1;
        adv(); adv();
        cyc("bgeu_branch", 1'b1, S_BRANCH);
        chk("bgeu_pcw", o_pc_write, 0);
        adv();
        cyc("bgeu_done", 1'b1, S_FETCH);
        i_ltu = 1'b0;

        // LW with two not-ready cycles in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        adv(); adv();
        cyc("lw_memadr", 1'b1, S_MEMADR);
        chk("lw_imm", o_imm_src, 0);
        chk("lw_memadr_rw", o_reg_write, 0);
        adv();
        for (int i = 0; i < 3; i++) begin
            cyc("lw_memread", (i == 2), S_MEMREAD);
            chk("lw_adr", o_adr_src, 1);
            chk("lw_memread_rw", o_reg_write, 0);
            adv();
        end
        cyc("lw_memwb", 1'b1, S_MEMWB);
        chk("lw_wb_rw", o_reg_write, 1);
        chk("lw_wb_res", o_result_src, 1);
        adv();
        cyc("lw_done", 1'b1, S_FETCH);
        chk("lw_done_rw", o_reg_write, 0);

        // SW with three not-ready cycles: mem_write held four cycles
        set_instr(7'b0100011, 3'b010, 1'b0);
        adv(); adv();
        cyc("sw_memadr", 1'b1, S_MEMADR);
        chk("sw_imm", o_imm_src, 1);
        chk("sw_memadr_mw", o_mem_write, 0);
        adv();
        for (int i = 0; i < 4; i++) begin
            cyc("sw_memwrite", (i == 3), S_MEMWRITE);
            chk("sw_mw", o_mem_write, 1);
            chk("sw_adr", o_adr_src, 1);
            adv();
        end
        cyc("sw_done", 1'b1, S_FETCH);
        chk("sw_done_mw", o_mem_write, 0);

        // Unsupported opcode
        set_instr(7'b0000000, 3'd0, 1'b0);
        chk("ill_fetch", o_illegal, 0);
        adv();
        cyc("ill_decode", 1'b1, S_DECODE);
        chk("ill_pulse", o_illegal, 1);
        adv();
        cyc("ill_done", 1'b1, S_FETCH);
        chk("ill_clear", o_illegal, 0);

        // Reset in the middle of a store wait
        set_instr(7'b0100011, 3'b010, 1'b0);
        adv(); adv(); adv();
        cyc("rstw_memwrite", 1'b0, S_MEMWRITE);
        chk("rstw_mw_before", o_mem_write, 1);
        i_rst = 1'b1;
        #1;
        chk("rstw_mw_dropped", o_mem_write, 0);
        adv();
        i_rst = 1'b0;
        cyc("rstw_state", 1'b0, S_FETCH);
        adv();

        // Randomized instructions against a timeline model built from the latency rules
        for (int n = 0; n < 200; n++) begin
            opc = opc_tab[$urandom_range(0, 13)];
            f3  = 3'($urandom_range(0, 7));
            f7  = 1'($urandom_range(0, 1));
            z   = 1'($urandom_range(0, 1));
            lt  = 1'($urandom_range(0, 1));
            ltu = 1'($urandom_range(0, 1));
            kf  = $urandom_range(0, 2);
            km  = $urandom_range(0, 3);
            d   = kf + 1;
            pcw2 = -1; rw = -1; mw_lo = -1; mw_hi = -2; ill = -1; mdone = -1; alu_cyc = -1;
            alu_exp = 4'd0;
            taken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? lt :
                    (f3 == 3'd5) ? !lt : (f3 == 3'd6) ? ltu : (f3 == 3'd7) ? !ltu : 1'b0;
            case (opc)
                7'b0110011: begin
                    total = d + 3; rw = d + 2; alu_cyc = d + 1;
                    alu_exp = (f3 == 3'd0 && f7) ? 4'd1 : (f3 == 3'd5 && f7) ? 4'd7 : base_op[f3];
                end
                7'b0010011: begin
                    total = d + 3; rw = d + 2; alu_cyc = d + 1;
                    alu_exp = (f3 == 3'd5 && f7) ? 4'd7 : base_op[f3];
                end
                7'b0110111, 7'b0010111: begin
                    total = d + 3; rw = d + 2; alu_cyc = d + 1;
                end
                7'b1101111: begin total = d + 3; pcw2 = d + 1; rw = d + 2; end
                7'b1100111: begin total = d + 3; pcw2 = d + 1; rw = d + 2; alu_cyc = d + 1; end
                7'b1100011: begin
                    total = d + 2; pcw2 = taken ? d + 1 : -1; alu_cyc = d + 1; alu_exp = 4'd1;
                end
                7'b0000011: begin mdone = d + 2 + km; rw = mdone + 1; total = mdone + 2; end
                7'b0100011: begin mdone = d + 2 + km; mw_lo = d + 2; mw_hi = mdone; total = mdone + 1; end
                7'b0001111, 7'b1110011: total = d + 1;
                default: begin ill = d; total = d + 1; end
            endcase
            set_instr(opc, f3, f7);
            i_zero = z; i_lt = lt; i_ltu = ltu;
            for (int c = 0; c < total; c++) begin
                if (c == kf || c == mdone)                     rdy = 1'b1;
                else if (c < kf || (mdone >= 0 && c >= d + 2)) rdy = 1'b0;
                else                                           rdy = 1'($urandom_range(0, 1));
                i_mem_ready = rdy;
                #4;
                if (c == 0) chk("rnd_start", o_state, S_FETCH);
                chk("rnd_pcw", o_pc_write, (c == kf || c == pcw2));
                chk("rnd_irw", o_ir_write, (c == kf));
                chk("rnd_rw", o_reg_write, (c == rw));
                chk("rnd_mw", o_mem_write, (c >= mw_lo && c <= mw_hi));
                chk("rnd_ill", o_illegal, (c == ill));
                if (c == alu_cyc) chk("rnd_alu", o_alu_ctrl, alu_exp);
                adv();
            end
            i_mem_ready = 1'b0;
            #4;
            chk("rnd_end", o_state, S_FETCH);
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
